bus_control_unit: RTL and testbench
===================================

# bus_control_unit

Bus control unit (BCU) for the v30mz core. It owns the single 16-bit external bus and shares it between the prefetch queue (code fetch) and the execution unit (data read/write). It sequences each bus cycle against the active-low `readyb` handshake, steers byte lanes for odd addresses, and splits misaligned word accesses into two byte cycles. It sits between the core's prefetch queue / EXU and the external memory interface, replacing the inline prefetch logic in the core's top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-state limit per bus cycle. Only used when the timeout feature is compiled in.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `readyb`  in  1  memory ready, active-low; sampled every cycle while a bus cycle is active.
- `data_in`  in  16  read data bus.
- `address_out`  out  20  physical address.
- `bus_status`  out  4  cycle type: F = passive, 9 = code fetch, A = memory read, B = memory write.
- `data_out`  out  16  write data bus.
- `bus_bytesel`  out  2  lane enables: [0] = low byte (even address), [1] = high byte.
- `pf_req`  in  1  prefetch wanted; level signal, queue not full.
- `pf_addr`  in  20  physical prefetch address.
- `pf_push`  out  1  one-cycle pulse: `pf_data` is valid.
- `pf_data`  out  16  fetched code bytes.
- `pf_single`  out  1  with `pf_push`: only `pf_data[7:0]` is valid.
- `flush`  in  1  one-cycle pulse: discard any in-flight prefetch.
- `exu_req`  in  1  data access request; held high until `exu_ack`.
- `exu_we`  in  1  1 = write.
- `exu_word`  in  1  1 = 16-bit access, 0 = 8-bit access.
- `exu_addr`  in  20  physical data address.
- `exu_wdata`  in  16  write data.
- `exu_ack`  out  1  one-cycle pulse: access complete.
- `exu_rdata`  out  16  read data, valid with `exu_ack`.
- `timeout`  out  1  one-cycle pulse on wait-state abort; present only when the macro is defined.

## Operation
- **States:** IDLE, BUS1, BUS2. Requests are latched on entry to BUS1. Inputs `pf_addr`, `exu_*` are ignored mid-cycle.
- **Arbitration (IDLE):**
  - `exu_req` has priority over `pf_req`.
  - No preemption of an active cycle.
  - With no request, stay in IDLE: `bus_status` = F, `bus_bytesel` = 00.
- **BUS1:** drive address, status and lanes. On `readyb` = 0:
  - misaligned word (`exu_word` and `exu_addr[0]`) goes to BUS2;
  - otherwise go to IDLE, pulsing `pf_push` or `exu_ack` in the IDLE cycle.
- **BUS2:** address = latched address + 1 (20-bit wrap, FFFFF to 00000), lane 0. On `readyb` = 0, go to IDLE with `exu_ack`.
- **Lane rules:**
  - Even byte access: lane 01, data on [7:0].
  - Odd byte access: lane 10, data on [15:8].
  - Aligned word: lane 11.
  - Reads are right-justified into `exu_rdata`; the upper byte is 0 for byte reads.
  - Byte writes put `exu_wdata[7:0]` on both halves of `data_out`.
  - Misaligned word: BUS1 transfers the low byte on lane 10; BUS2 transfers the high byte on lane 01.
- **Prefetch:**
  - Even `pf_addr`: word fetch, `pf_single` = 0.
  - Odd `pf_addr`: lane 10, `pf_data` = {00, `data_in[15:8]`}, `pf_single` = 1.
- **Flush:** a flush during BUS1 of a code fetch, or in the completing cycle, suppresses that `pf_push`. The bus cycle still runs to completion. Flush has no effect on EXU cycles or in IDLE.
- **Reset** (including mid-cycle), next edge:
  - state = IDLE, `address_out` = 00000, `bus_status` = F;
  - `data_out`, `bus_bytesel`, `pf_data`, `exu_rdata` = 0;
  - all pulses (`pf_push`, `pf_single`, `exu_ack`, `timeout`) = 0.

## Timing
- Minimum cycle: request seen in IDLE at edge N; BUS1 during cycle N+1; `readyb` = 0 at edge N+2; pulse during cycle N+2 (IDLE).
- A single zero-wait access therefore costs 2 clocks; a misaligned word costs 3.
- Each wait state (`readyb` = 1) adds 1 clock per phase.
- Outputs are registered; `bus_status` returns to F for at least one cycle between bus cycles.
- A request asserted during the pulse cycle is arbitrated in that same IDLE cycle (back-to-back period = 2 clocks).

## Configuration
- **`BCU_WAIT_TIMEOUT_EN` defined:**
  - A wait counter resets on entry to BUS1/BUS2.
  - When `TIMEOUT_CYCLES` consecutive `readyb` = 1 samples are reached, the cycle terminates as if ready, with read data forced to FFFF. A misaligned word is aborted in its current phase.
  - `timeout` pulses together with `exu_ack` / `pf_push`.
- **Undefined:** wait indefinitely; no counter and no `timeout` port.

## Structure
- Shared package `v30mz_pkg`: bus status constants (`BUS_PASSIVE`, `BUS_CODE`, `BUS_MEM_RD`, `BUS_MEM_WR`), BCU state enum, lane enable constants.
- One sub-module, `bus_lane_align` (combinational): given address[0], size, phase and write data, produces `bus_bytesel`, `data_out` and the read-data extraction.

## Test plan
- `pf_req` = 1 with `pf_addr` = FFFF0, `readyb` tied 0 → status 9, lanes 11, a `pf_push` every 2 clocks, `pf_single` = 0.
- `pf_req` and `exu_req` (read byte at 00101) asserted together, `data_in` = 5AA5 → EXU served first with lane 10 and `exu_rdata` = 005A, then the fetch.
- EXU word write at 00203 with data 1234 → BUS1 at 00203 with lane 10 and `data_out[15:8]` = 34; BUS2 at 00204 with lane 01 and `data_out[7:0]` = 12; a single `exu_ack`.
- Code fetch held with `readyb` = 1 for 3 cycles and `flush` pulsed mid-cycle → cycle completes after the waits, no `pf_push`.
- Reset asserted during BUS2 → next cycle IDLE with status F, no `exu_ack`; with the macro and `TIMEOUT_CYCLES` = 4 plus `readyb` stuck 1 → `timeout` and `exu_ack` after 4 wait states, `exu_rdata` = FFFF.

Source files
------------

// File: rtl/v30mz_pkg.sv
// v30mz_pkg: shared bus-status codes, lane-enable codes and the BCU state enum.
// No ports; imported by bus_control_unit and bus_lane_align.
package v30mz_pkg;
    localparam logic [3:0] BUS_PASSIVE = 4'hF;
    localparam logic [3:0] BUS_CODE    = 4'h9;
    localparam logic [3:0] BUS_MEM_RD  = 4'hA;
    localparam logic [3:0] BUS_MEM_WR  = 4'hB;
    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_WORD = 2'b11;
    typedef enum logic [1:0] {BCU_IDLE, BCU_BUS1, BCU_BUS2} bcu_state_t;
endpackage

// File: rtl/bus_lane_align.sv
// bus_lane_align: combinational byte-lane steering for the BCU.
// Ports: i_addr0/i_word/i_phase2/i_wdata describe the phase about to be driven
// (-> o_bytesel, o_data_out); i_lanes is the lane set of the phase now on the bus,
// used with i_bus_data to produce the right-justified o_rdata.
module bus_lane_align
    import v30mz_pkg::*;
(
    input  logic        i_addr0,
    input  logic        i_word,
    input  logic        i_phase2,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_lanes,
    input  logic [15:0] i_bus_data,
    output logic [1:0]  o_bytesel,
    output logic [15:0] o_data_out,
    output logic [15:0] o_rdata
);
    logic       w_aligned_word;
    logic [7:0] w_byte;
    assign w_aligned_word = i_word & ~i_addr0 & ~i_phase2;
    // second phase of a split word carries the high byte
    assign w_byte     = i_phase2 ? i_wdata[15:8] : i_wdata[7:0];
    assign o_bytesel  = w_aligned_word ? LANE_WORD : (i_addr0 & ~i_phase2) ? LANE_HI : LANE_LO;
    assign o_data_out = w_aligned_word ? i_wdata : {w_byte, w_byte};
    assign o_rdata    = (i_lanes == LANE_WORD) ? i_bus_data :
                        {8'h00, (i_lanes == LANE_HI) ? i_bus_data[15:8] : i_bus_data[7:0]};
endmodule

// File: rtl/bus_control_unit.sv
// bus_control_unit: owns the 16-bit external bus, arbitrating EXU data accesses
// (priority) against prefetch code fetches, sequencing against active-low readyb,
// steering odd-address lanes and splitting misaligned words into two byte cycles.
// Ports: clk, reset (sync, active-high); memory side readyb, data_in, address_out,
// bus_status, data_out, bus_bytesel; prefetch side pf_req, pf_addr, pf_push,
// pf_data, pf_single, flush; EXU side exu_req, exu_we, exu_word, exu_addr,
// exu_wdata, exu_ack, exu_rdata.
// Option BCU_WAIT_TIMEOUT_EN: adds TIMEOUT_CYCLES and the timeout pulse output;
// a phase that sees TIMEOUT_CYCLES consecutive wait states ends with data FFFF.
module bus_control_unit
    import v30mz_pkg::*;
`ifdef BCU_WAIT_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        readyb,
    input  logic [15:0] data_in,
    output logic [19:0] address_out,
    output logic [3:0]  bus_status,
    output logic [15:0] data_out,
    output logic [1:0]  bus_bytesel,
    input  logic        pf_req,
    input  logic [19:0] pf_addr,
    output logic        pf_push,
    output logic [15:0] pf_data,
    output logic        pf_single,
    input  logic        flush,
    input  logic        exu_req,
    input  logic        exu_we,
    input  logic        exu_word,
    input  logic [19:0] exu_addr,
    input  logic [15:0] exu_wdata,
    output logic        exu_ack,
    output logic [15:0] exu_rdata
`ifdef BCU_WAIT_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);
    bcu_state_t  r_state, w_next;
    logic        r_exu, r_we, r_word, r_flushed;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic [7:0]  r_lo;
    logic        w_start, w_ready, w_split, w_done, w_to;
    logic        w_n_exu, w_n_we, w_n_word;
    logic [19:0] w_n_addr;
    logic [15:0] w_n_wdata;
    logic [1:0]  w_bytesel, w_sel_nxt;
    logic [15:0] w_data_out, w_rdata, w_dout_nxt, w_pfd_nxt, w_rd_nxt;
    logic [19:0] w_addr_nxt;
    logic [3:0]  w_stat_nxt;
    logic        w_push_nxt, w_single_nxt, w_ack_nxt;

`ifdef BCU_WAIT_TIMEOUT_EN
    logic [15:0] r_wait;
    assign w_to = readyb && (r_state != BCU_IDLE) && (r_wait == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_to = 1'b0;
`endif

    assign w_start = (r_state == BCU_IDLE) && (exu_req || pf_req);
    assign w_ready = ~readyb | w_to;
    // a timed-out first phase of a split word is abandoned rather than continued
    assign w_split = r_word & r_addr[0] & ~w_to;
    assign w_done  = (r_state != BCU_IDLE) && (w_next == BCU_IDLE);

    // fields of the phase about to be driven: fresh request on start, else latched
    assign w_n_exu   = w_start ? exu_req : r_exu;
    assign w_n_we    = w_start ? (exu_req & exu_we) : r_we;
    assign w_n_word  = w_start ? (exu_req ? exu_word : ~pf_addr[0]) : r_word;
    assign w_n_addr  = w_start ? (exu_req ? exu_addr : pf_addr) : r_addr;
    assign w_n_wdata = w_start ? exu_wdata : r_wdata;

    bus_lane_align u_lane (
        .i_addr0    (w_n_addr[0]),
        .i_word     (w_n_word),
        .i_phase2   (w_next == BCU_BUS2),
        .i_wdata    (w_n_wdata),
        .i_lanes    (bus_bytesel),
        .i_bus_data (data_in),
        .o_bytesel  (w_bytesel),
        .o_data_out (w_data_out),
        .o_rdata    (w_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            BCU_IDLE: w_next = w_start ? BCU_BUS1 : BCU_IDLE;
            BCU_BUS1: w_next = w_ready ? (w_split ? BCU_BUS2 : BCU_IDLE) : BCU_BUS1;
            BCU_BUS2: w_next = w_ready ? BCU_IDLE : BCU_BUS2;
            default:  w_next = BCU_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt   = (w_next == BCU_IDLE) ? 20'h00000 : (w_next == BCU_BUS2) ? r_addr + 20'd1 : w_n_addr;
        w_stat_nxt   = (w_next == BCU_IDLE) ? BUS_PASSIVE : !w_n_exu ? BUS_CODE : w_n_we ? BUS_MEM_WR : BUS_MEM_RD;
        w_sel_nxt    = (w_next == BCU_IDLE) ? LANE_NONE : w_bytesel;
        w_dout_nxt   = (w_next == BCU_IDLE) ? 16'h0000 : w_data_out;
        w_push_nxt   = w_done & ~r_exu & ~r_flushed & ~flush;
        w_single_nxt = w_push_nxt & r_addr[0];
        w_pfd_nxt    = w_push_nxt ? (w_to ? 16'hFFFF : w_rdata) : pf_data;
        w_ack_nxt    = w_done & r_exu;
        w_rd_nxt     = !w_ack_nxt ? exu_rdata : w_to ? 16'hFFFF :
                       (r_state == BCU_BUS2) ? {w_rdata[7:0], r_lo} : w_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BCU_IDLE;
            r_exu       <= 1'b0;
            r_we        <= 1'b0;
            r_word      <= 1'b0;
            r_addr      <= 20'h00000;
            r_wdata     <= 16'h0000;
            r_flushed   <= 1'b0;
            r_lo        <= 8'h00;
            address_out <= 20'h00000;
            bus_status  <= BUS_PASSIVE;
            bus_bytesel <= LANE_NONE;
            data_out    <= 16'h0000;
            pf_push     <= 1'b0;
            pf_single   <= 1'b0;
            pf_data     <= 16'h0000;
            exu_ack     <= 1'b0;
            exu_rdata   <= 16'h0000;
`ifdef BCU_WAIT_TIMEOUT_EN
            r_wait      <= 16'h0000;
            timeout     <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            address_out <= w_addr_nxt;
            bus_status  <= w_stat_nxt;
            bus_bytesel <= w_sel_nxt;
            data_out    <= w_dout_nxt;
            pf_push     <= w_push_nxt;
            pf_single   <= w_single_nxt;
            pf_data     <= w_pfd_nxt;
            exu_ack     <= w_ack_nxt;
            exu_rdata   <= w_rd_nxt;
            if (w_start) begin
                r_exu     <= w_n_exu;
                r_we      <= w_n_we;
                r_word    <= w_n_word;
                r_addr    <= w_n_addr;
                r_wdata   <= w_n_wdata;
                r_flushed <= 1'b0;
            end else if (r_state == BCU_BUS1 && !r_exu && flush) begin
                r_flushed <= 1'b1;
            end
            if (r_state == BCU_BUS1 && w_next == BCU_BUS2)
                r_lo <= w_rdata[7:0];
`ifdef BCU_WAIT_TIMEOUT_EN
            r_wait  <= (w_next != r_state) ? 16'h0000 : (r_state != BCU_IDLE && readyb) ? r_wait + 16'd1 : r_wait;
            timeout <= w_done & w_to;
`endif
        end
    end
endmodule

// File: tb/tb_bus_control_unit.sv
// tb_bus_control_unit: directed self-checking bench for bus_control_unit
module tb_bus_control_unit;
  logic        clk = 1'b0;
  logic        reset, readyb, pf_req, flush, exu_req, exu_we, exu_word;
  logic [15:0] data_in, exu_wdata;
  logic [19:0] pf_addr, exu_addr;
  logic [19:0] address_out;
  logic [3:0]  bus_status;
  logic [15:0] data_out, pf_data, exu_rdata;
  logic [1:0]  bus_bytesel;
  logic        pf_push, pf_single, exu_ack;
  int          checks = 0;
  int          errors = 0;
`ifdef BCU_WAIT_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

`ifdef BCU_WAIT_TIMEOUT_EN
  bus_control_unit #(.TIMEOUT_CYCLES(4)) dut (.*);
`else
  bus_control_unit dut (.*);
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; readyb = 1'b1; pf_req = 1'b0; flush = 1'b0; exu_req = 1'b0;
    exu_we = 1'b0; exu_word = 1'b0; data_in = 16'h0; exu_wdata = 16'h0;
    pf_addr = 20'h0; exu_addr = 20'h0;
    tick; tick;
    checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL reset_status: got %h exp F", bus_status); end
    checks++; if (address_out !== 20'h00000) begin errors++; $display("FAIL reset_addr: got %h exp 00000", address_out); end
    checks++; if ({bus_bytesel, data_out, pf_data, exu_rdata} !== 50'h0) begin errors++; $display("FAIL reset_data: got %h %h %h %h exp 0", bus_bytesel, data_out, pf_data, exu_rdata); end
    checks++; if ({pf_push, pf_single, exu_ack} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {pf_push, pf_single, exu_ack}); end
    reset = 1'b0;
    tick;
    checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL idle_status: got %h exp F", bus_status); end
  endtask

  task automatic test_prefetch_stream;
    pf_req = 1'b1; pf_addr = 20'hFFFF0; readyb = 1'b0; data_in = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if ({bus_status, bus_bytesel, address_out, pf_push} !== {4'h9, 2'b11, 20'hFFFF0, 1'b0}) begin errors++; $display("FAIL pf_bus1[%0d]: got %h %b %h %b exp 9 11 FFFF0 0", i, bus_status, bus_bytesel, address_out, pf_push); end
      tick;
      checks++; if ({pf_push, pf_single, pf_data, bus_status} !== {1'b1, 1'b0, 16'hBEEF, 4'hF}) begin errors++; $display("FAIL pf_push[%0d]: got %b %b %h %h exp 1 0 BEEF F", i, pf_push, pf_single, pf_data, bus_status); end
    end
    pf_req = 1'b0;
    tick;
    checks++; if ({bus_status, pf_push} !== {4'hF, 1'b0}) begin errors++; $display("FAIL pf_stop: got %h %b exp F 0", bus_status, pf_push); end
  endtask

  task automatic test_arbitration;
    pf_req = 1'b1; pf_addr = 20'h00200; exu_req = 1'b1; exu_we = 1'b0; exu_word = 1'b0;
    exu_addr = 20'h00101; data_in = 16'h5AA5; readyb = 1'b0;
    tick;
    checks++; if ({bus_status, bus_bytesel, address_out} !== {4'hA, 2'b10, 20'h00101}) begin errors++; $display("FAIL arb_exu_first: got %h %b %h exp A 10 00101", bus_status, bus_bytesel, address_out); end
    tick;
    checks++; if ({exu_ack, exu_rdata, pf_push} !== {1'b1, 16'h005A, 1'b0}) begin errors++; $display("FAIL arb_exu_ack: got %b %h %b exp 1 005A 0", exu_ack, exu_rdata, pf_push); end
    exu_req = 1'b0;
    tick;
    checks++; if ({bus_status, bus_bytesel, address_out} !== {4'h9, 2'b11, 20'h00200}) begin errors++; $display("FAIL arb_fetch: got %h %b %h exp 9 11 00200", bus_status, bus_bytesel, address_out); end
    pf_req = 1'b0;
    tick;
    checks++; if ({pf_push, pf_data, exu_ack} !== {1'b1, 16'h5AA5, 1'b0}) begin errors++; $display("FAIL arb_push: got %b %h %b exp 1 5AA5 0", pf_push, pf_data, exu_ack); end
  endtask

  task automatic test_byte_lanes;
    exu_req = 1'b1; exu_we = 1'b1; exu_word = 1'b0; exu_addr = 20'h00400; exu_wdata = 16'h77C3; readyb = 1'b0;
    tick;
    checks++; if ({bus_status, bus_bytesel, data_out} !== {4'hB, 2'b01, 16'hC3C3}) begin errors++; $display("FAIL even_byte_wr: got %h %b %h exp B 01 C3C3", bus_status, bus_bytesel, data_out); end
    tick; exu_req = 1'b0;
    exu_req = 1'b1; exu_we = 1'b0; exu_word = 1'b1; exu_addr = 20'h00500; data_in = 16'h1357;
    tick;
    checks++; if ({bus_status, bus_bytesel} !== {4'hA, 2'b11}) begin errors++; $display("FAIL word_rd_lanes: got %h %b exp A 11", bus_status, bus_bytesel); end
    tick;
    checks++; if ({exu_ack, exu_rdata} !== {1'b1, 16'h1357}) begin errors++; $display("FAIL word_rd_data: got %b %h exp 1 1357", exu_ack, exu_rdata); end
    exu_word = 1'b0; exu_addr = 20'h00100; data_in = 16'h5AA5;
    tick; tick;
    checks++; if ({exu_ack, exu_rdata} !== {1'b1, 16'h00A5}) begin errors++; $display("FAIL even_byte_rd: got %b %h exp 1 00A5", exu_ack, exu_rdata); end
    exu_req = 1'b0;
    tick;
  endtask

  task automatic test_misaligned;
    exu_req = 1'b1; exu_we = 1'b1; exu_word = 1'b1; exu_addr = 20'h00203; exu_wdata = 16'h1234; readyb = 1'b0;
    tick;
    checks++; if ({bus_status, address_out, bus_bytesel, data_out[15:8]} !== {4'hB, 20'h00203, 2'b10, 8'h34}) begin errors++; $display("FAIL mis_wr_bus1: got %h %h %b %h exp B 00203 10 34", bus_status, address_out, bus_bytesel, data_out[15:8]); end
    tick;
    checks++; if ({address_out, bus_bytesel, data_out[7:0], exu_ack} !== {20'h00204, 2'b01, 8'h12, 1'b0}) begin errors++; $display("FAIL mis_wr_bus2: got %h %b %h %b exp 00204 01 12 0", address_out, bus_bytesel, data_out[7:0], exu_ack); end
    tick;
    checks++; if ({exu_ack, bus_status} !== {1'b1, 4'hF}) begin errors++; $display("FAIL mis_wr_ack: got %b %h exp 1 F", exu_ack, bus_status); end
    exu_req = 1'b0;
    tick;
    checks++; if (exu_ack !== 1'b0) begin errors++; $display("FAIL mis_wr_single_ack: got %b exp 0", exu_ack); end
    exu_req = 1'b1; exu_we = 1'b0; exu_word = 1'b1; exu_addr = 20'hFFFFF; data_in = 16'hAB00;
    tick;
    checks++; if ({bus_status, address_out, bus_bytesel} !== {4'hA, 20'hFFFFF, 2'b10}) begin errors++; $display("FAIL mis_rd_bus1: got %h %h %b exp A FFFFF 10", bus_status, address_out, bus_bytesel); end
    tick;
    checks++; if ({address_out, bus_bytesel} !== {20'h00000, 2'b01}) begin errors++; $display("FAIL mis_rd_wrap: got %h %b exp 00000 01", address_out, bus_bytesel); end
    data_in = 16'h00CD;
    tick;
    checks++; if ({exu_ack, exu_rdata} !== {1'b1, 16'hCDAB}) begin errors++; $display("FAIL mis_rd_data: got %b %h exp 1 CDAB", exu_ack, exu_rdata); end
    exu_req = 1'b0;
    tick;
  endtask

  task automatic test_wait_flush;
    pf_req = 1'b1; pf_addr = 20'h00300; readyb = 1'b1; data_in = 16'h4321;
    tick;
    pf_req = 1'b0;
    checks++; if (bus_status !== 4'h9) begin errors++; $display("FAIL wf_start: got %h exp 9", bus_status); end
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
    checks++; if ({bus_status, address_out, pf_push} !== {4'h9, 20'h00300, 1'b0}) begin errors++; $display("FAIL wf_waiting: got %h %h %b exp 9 00300 0", bus_status, address_out, pf_push); end
    readyb = 1'b0;
    tick;
    checks++; if ({bus_status, pf_push} !== {4'hF, 1'b0}) begin errors++; $display("FAIL wf_suppressed: got %h %b exp F 0", bus_status, pf_push); end
    pf_req = 1'b1; pf_addr = 20'h00301; data_in = 16'h5AA5;
    tick;
    pf_req = 1'b0;
    checks++; if (bus_bytesel !== 2'b10) begin errors++; $display("FAIL odd_pf_lane: got %b exp 10", bus_bytesel); end
    tick;
    checks++; if ({pf_push, pf_single, pf_data} !== {1'b1, 1'b1, 16'h005A}) begin errors++; $display("FAIL odd_pf_push: got %b %b %h exp 1 1 005A", pf_push, pf_single, pf_data); end
    pf_req = 1'b1; pf_addr = 20'h00302; flush = 1'b1;
    tick;
    pf_req = 1'b0; flush = 1'b0;
    tick;
    checks++; if (pf_push !== 1'b1) begin errors++; $display("FAIL idle_flush_ignored: got %b exp 1", pf_push); end
  endtask

  task automatic test_reset_mid;
    exu_req = 1'b1; exu_we = 1'b1; exu_word = 1'b1; exu_addr = 20'h00701; exu_wdata = 16'hA55A; readyb = 1'b0;
    tick; tick;
    checks++; if (address_out !== 20'h00702) begin errors++; $display("FAIL rm_in_bus2: got %h exp 00702", address_out); end
    reset = 1'b1;
    tick;
    reset = 1'b0; exu_req = 1'b0;
    checks++; if ({bus_status, address_out, bus_bytesel, exu_ack} !== {4'hF, 20'h00000, 2'b00, 1'b0}) begin errors++; $display("FAIL rm_idle: got %h %h %b %b exp F 00000 00 0", bus_status, address_out, bus_bytesel, exu_ack); end
    tick;
    checks++; if (exu_ack !== 1'b0) begin errors++; $display("FAIL rm_no_ack: got %b exp 0", exu_ack); end
  endtask

`ifdef BCU_WAIT_TIMEOUT_EN
  task automatic test_timeout;
    exu_req = 1'b1; exu_we = 1'b0; exu_word = 1'b0; exu_addr = 20'h00600; readyb = 1'b1; data_in = 16'h1111;
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if ({exu_ack, timeout} !== 2'b00) begin errors++; $display("FAIL to_wait[%0d]: got %b %b exp 0 0", i, exu_ack, timeout); end
    end
    tick;
    checks++; if ({exu_ack, timeout, exu_rdata} !== {1'b1, 1'b1, 16'hFFFF}) begin errors++; $display("FAIL to_abort: got %b %b %h exp 1 1 FFFF", exu_ack, timeout, exu_rdata); end
    exu_req = 1'b0; readyb = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_prefetch_stream;
    test_arbitration;
    test_byte_lanes;
    test_misaligned;
    test_wait_flush;
    test_reset_mid;
`ifdef BCU_WAIT_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
